// File: rtl/sprite_scheduler_if.sv
// Position-update port of the sprite scheduler: one sprite position per accepted
// valid/ready transfer.
interface sprite_scheduler_if #(
   parameter int NUM_SPRITES = 4
) ();
   localparam int IDW = $clog2(NUM_SPRITES);

   logic           pos_valid_in;
   logic           pos_ready_out;
   logic [IDW-1:0] pos_id_in;
   logic [10:0]    pos_x_in;
   logic [9:0]     pos_y_in;
   logic           pos_en_in;

   modport master (
      output pos_valid_in, pos_id_in, pos_x_in, pos_y_in, pos_en_in,
      input  pos_ready_out
   );

   modport slave (
      input  pos_valid_in, pos_id_in, pos_x_in, pos_y_in, pos_en_in,
      output pos_ready_out
   );
endinterface

// File: rtl/sprite_scheduler.sv
// Per-pixel sprite picker sharing one image ROM; positions are double-buffered
// and committed at frame start so a frame never mixes old and new positions.
module sprite_scheduler #(
   parameter int NUM_SPRITES = 4,
   parameter int WIDTH       = 32,
   parameter int HEIGHT      = 32,
   parameter int ROM_LATENCY = 2,
   parameter int PAL_LATENCY = 2
) (
   input  logic                                        pixel_clk_in,
   input  logic                                        rst_n_in,
   input  logic [10:0]                                 hcount_in,
   input  logic [9:0]                                  vcount_in,
   input  logic                                        frame_start_in,
   sprite_scheduler_if.slave                           pos_if,
   output logic [$clog2(NUM_SPRITES*WIDTH*HEIGHT)-1:0] rom_addr_out,
   output logic                                        hit_out,
   output logic [$clog2(NUM_SPRITES)-1:0]              sprite_id_out
);
   localparam int IDW   = $clog2(NUM_SPRITES);
   localparam int AW    = $clog2(NUM_SPRITES*WIDTH*HEIGHT);
   localparam int DEPTH = ROM_LATENCY + PAL_LATENCY;

   typedef enum logic [0:0] {
      ST_OPEN   = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   state_t state_r;
   state_t state_next_s;
   logic   ready_r;
   logic   accept_s;

   logic [10:0] sh_x_r   [NUM_SPRITES];
   logic [9:0]  sh_y_r   [NUM_SPRITES];
   logic        sh_en_r  [NUM_SPRITES];
   logic [10:0] act_x_r  [NUM_SPRITES];
   logic [9:0]  act_y_r  [NUM_SPRITES];
   logic        act_en_r [NUM_SPRITES];

   logic [NUM_SPRITES-1:0] cover_s;
   logic                   win_hit_s;
   logic [IDW-1:0]         win_id_s;
   logic [10:0]            dx_s;
   logic [9:0]             dy_s;
   logic [AW-1:0]          addr_s;

   logic [AW-1:0]  rom_addr_r;
   logic           hit_s1_r;
   logic [IDW-1:0] id_s1_r;
   logic           hit_pipe_r [DEPTH];
   logic [IDW-1:0] id_pipe_r  [DEPTH];

   assign pos_if.pos_ready_out = ready_r;
   assign accept_s             = pos_if.pos_valid_in && ready_r;

   // Next-state logic: COMMIT always lasts a single cycle.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_OPEN: begin
            if (frame_start_in) begin
               state_next_s = ST_COMMIT;
            end else begin
               state_next_s = ST_OPEN;
            end
         end
         ST_COMMIT: state_next_s = ST_OPEN;
         default:   state_next_s = ST_OPEN;
      endcase
   end

   // State register; ready is registered from the next state so it equals (state == OPEN).
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r <= ST_OPEN;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_next_s;
         ready_r <= (state_next_s == ST_OPEN);
      end
   end

   // Shadow and active position banks.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_x_r[i]   <= 11'd0;
            sh_y_r[i]   <= 10'd0;
            sh_en_r[i]  <= 1'b0;
            act_x_r[i]  <= 11'd0;
            act_y_r[i]  <= 10'd0;
            act_en_r[i] <= 1'b0;
         end
      end else begin
         if (accept_s) begin
            sh_x_r[pos_if.pos_id_in]  <= pos_if.pos_x_in;
            sh_y_r[pos_if.pos_id_in]  <= pos_if.pos_y_in;
            sh_en_r[pos_if.pos_id_in] <= pos_if.pos_en_in;
         end
         if (state_r == ST_COMMIT) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               act_x_r[i]  <= sh_x_r[i];
               act_y_r[i]  <= sh_y_r[i];
               act_en_r[i] <= sh_en_r[i];
            end
         end
      end
   end

   // Coverage test with one extra bit on each sum so edge sprites do not wrap;
   // scanning downward leaves the lowest covering index as the winner.
   always_comb begin
      cover_s   = {NUM_SPRITES{1'b0}};
      win_hit_s = 1'b0;
      win_id_s  = {IDW{1'b0}};
      for (int i = 0; i < NUM_SPRITES; i++) begin
         cover_s[i] = act_en_r[i]
            && ({1'b0, hcount_in} >= {1'b0, act_x_r[i]})
            && ({1'b0, hcount_in} <  ({1'b0, act_x_r[i]} + 12'(WIDTH)))
            && ({1'b0, vcount_in} >= {1'b0, act_y_r[i]})
            && ({1'b0, vcount_in} <  ({1'b0, act_y_r[i]} + 11'(HEIGHT)));
      end
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         win_hit_s = cover_s[i] ? 1'b1 : win_hit_s;
         win_id_s  = cover_s[i] ? IDW'(i) : win_id_s;
      end
   end

   // ROM address of the winning sprite's pixel, reduced modulo the address width.
   always_comb begin
      dx_s   = hcount_in - act_x_r[win_id_s];
      dy_s   = vcount_in - act_y_r[win_id_s];
      addr_s = AW'(win_id_s) * AW'(WIDTH * HEIGHT) + AW'(dy_s) * AW'(WIDTH) + AW'(dx_s);
   end

   // Stage 1 register plus the alignment delay line matching ROM and palette latency.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rom_addr_r <= {AW{1'b0}};
         hit_s1_r   <= 1'b0;
         id_s1_r    <= {IDW{1'b0}};
         for (int k = 0; k < DEPTH; k++) begin
            hit_pipe_r[k] <= 1'b0;
            id_pipe_r[k]  <= {IDW{1'b0}};
         end
      end else begin
         rom_addr_r    <= win_hit_s ? addr_s : {AW{1'b0}};
         hit_s1_r      <= win_hit_s;
         id_s1_r       <= win_hit_s ? win_id_s : {IDW{1'b0}};
         hit_pipe_r[0] <= hit_s1_r;
         id_pipe_r[0]  <= id_s1_r;
         for (int k = 1; k < DEPTH; k++) begin
            hit_pipe_r[k] <= hit_pipe_r[k-1];
            id_pipe_r[k]  <= id_pipe_r[k-1];
         end
      end
   end

   assign rom_addr_out  = rom_addr_r;
   assign hit_out       = hit_pipe_r[DEPTH-1];
   assign sprite_id_out = id_pipe_r[DEPTH-1];
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: shadow/commit behaviour, priority, address
// generation, output alignment, edge clipping and asynchronous reset.
module tb_sprite_scheduler;
   localparam logic [10:0] IDLE_H = 11'd1500;
   localparam logic [9:0]  IDLE_V = 10'd900;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        fs;
   logic [11:0] rom_addr;
   logic        hit;
   logic [1:0]  sid;
   int          total = 0;
   int          bad   = 0;

   logic [11:0] a;
   logic        h4, h5;
   logic [1:0]  i5;

   sprite_scheduler_if #(.NUM_SPRITES(4)) pif ();

   sprite_scheduler dut (
      .pixel_clk_in   (clk),
      .rst_n_in       (rst_n),
      .hcount_in      (hcount),
      .vcount_in      (vcount),
      .frame_start_in (fs),
      .pos_if         (pif.slave),
      .rom_addr_out   (rom_addr),
      .hit_out        (hit),
      .sprite_id_out  (sid)
   );

   always #5 clk = ~clk;

   // Present one pixel for one cycle, then idle; capture stage-1 address and the
   // aligned outputs four and five cycles later.
   task automatic run_pixel(input logic [10:0] h, input logic [9:0] v,
                            output logic [11:0] ao, output logic h4o,
                            output logic h5o, output logic [1:0] i5o);
      @(negedge clk); hcount = h; vcount = v;
      @(negedge clk); ao = rom_addr; hcount = IDLE_H; vcount = IDLE_V;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); h4o = hit;
      @(negedge clk); h5o = hit; i5o = sid;
   endtask

   task automatic write_pos(input logic [1:0] id, input logic [10:0] x,
                            input logic [9:0] y, input logic en);
      @(negedge clk);
      pif.pos_valid_in = 1'b1; pif.pos_id_in = id;
      pif.pos_x_in = x; pif.pos_y_in = y; pif.pos_en_in = en;
      @(negedge clk);
      pif.pos_valid_in = 1'b0;
   endtask

   task automatic frame_pulse();
      @(negedge clk); fs = 1'b1;
      @(negedge clk); fs = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pif.pos_valid_in = 1'b1; pif.pos_id_in = 2'd0;
      pif.pos_x_in = 11'd100; pif.pos_y_in = 10'd50; pif.pos_en_in = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (rom_addr !== 12'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
      total++; if (sid !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", sid); end
      total++; if (pif.pos_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", pif.pos_ready_out); end
      pif.pos_valid_in = 1'b0;
      rst_n = 1'b1;
      frame_pulse();
      run_pixel(11'd100, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL reset_no_write got=%b exp=0", h5); end
   endtask

   task automatic test_basic();
      write_pos(2'd0, 11'd100, 10'd50, 1'b1);
      frame_pulse();
      run_pixel(11'd100, 10'd50, a, h4, h5, i5);
      total++; if (a !== 12'd0) begin bad++; $display("FAIL basic_addr got=%0d exp=0", a); end
      total++; if (h4 !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", h4); end
      total++; if (h5 !== 1'b1) begin bad++; $display("FAIL basic_hit got=%b exp=1", h5); end
      total++; if (i5 !== 2'd0) begin bad++; $display("FAIL basic_id got=%0d exp=0", i5); end
      run_pixel(11'd131, 10'd81, a, h4, h5, i5);
      total++; if (a !== 12'd1023) begin bad++; $display("FAIL corner_addr got=%0d exp=1023", a); end
      total++; if (h5 !== 1'b1) begin bad++; $display("FAIL corner_hit got=%b exp=1", h5); end
      run_pixel(11'd132, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL right_miss got=%b exp=0", h5); end
      total++; if (a !== 12'd0) begin bad++; $display("FAIL miss_addr got=%0d exp=0", a); end
      run_pixel(11'd100, 10'd82, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL bottom_miss got=%b exp=0", h5); end
   endtask

   task automatic test_priority();
      write_pos(2'd2, 11'd10, 10'd10, 1'b1);
      write_pos(2'd1, 11'd20, 10'd20, 1'b1);
      frame_pulse();
      run_pixel(11'd25, 10'd25, a, h4, h5, i5);
      total++; if (i5 !== 2'd1) begin bad++; $display("FAIL overlap_id got=%0d exp=1", i5); end
      total++; if (a !== 12'd1189) begin bad++; $display("FAIL overlap_addr got=%0d exp=1189", a); end
      run_pixel(11'd11, 10'd11, a, h4, h5, i5);
      total++; if (i5 !== 2'd2 || h5 !== 1'b1) begin bad++; $display("FAIL id2_hit got=%0d/%b exp=2/1", i5, h5); end
      total++; if (a !== 12'd2081) begin bad++; $display("FAIL id2_addr got=%0d exp=2081", a); end
   endtask

   task automatic test_shadow_commit();
      write_pos(2'd0, 11'd200, 10'd50, 1'b1);
      run_pixel(11'd100, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b1 || i5 !== 2'd0) begin bad++; $display("FAIL shadow_old got=%b/%0d exp=1/0", h5, i5); end
      run_pixel(11'd200, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL shadow_new_early got=%b exp=0", h5); end
      @(negedge clk); fs = 1'b1;
      total++; if (pif.pos_ready_out !== 1'b1) begin bad++; $display("FAIL ready_before got=%b exp=1", pif.pos_ready_out); end
      @(negedge clk); fs = 1'b0;
      total++; if (pif.pos_ready_out !== 1'b0) begin bad++; $display("FAIL ready_commit got=%b exp=0", pif.pos_ready_out); end
      @(negedge clk);
      total++; if (pif.pos_ready_out !== 1'b1) begin bad++; $display("FAIL ready_after got=%b exp=1", pif.pos_ready_out); end
      run_pixel(11'd200, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b1 || a !== 12'd0) begin bad++; $display("FAIL moved_hit got=%b/%0d exp=1/0", h5, a); end
      run_pixel(11'd100, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL moved_old got=%b exp=0", h5); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      pif.pos_valid_in = 1'b1; pif.pos_id_in = 2'd3;
      pif.pos_x_in = 11'd300; pif.pos_y_in = 10'd300; pif.pos_en_in = 1'b1;
      @(negedge clk);
      pif.pos_x_in = 11'd400; pif.pos_y_in = 10'd400; fs = 1'b1;
      @(negedge clk);
      pif.pos_valid_in = 1'b0; fs = 1'b0;
      total++; if (pif.pos_ready_out !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b exp=0", pif.pos_ready_out); end
      run_pixel(11'd400, 10'd400, a, h4, h5, i5);
      total++; if (h5 !== 1'b1 || i5 !== 2'd3) begin bad++; $display("FAIL b2b_hit got=%b/%0d exp=1/3", h5, i5); end
      total++; if (a !== 12'd3072) begin bad++; $display("FAIL b2b_addr got=%0d exp=3072", a); end
      run_pixel(11'd300, 10'd300, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b exp=0", h5); end
   endtask

   task automatic test_edge();
      write_pos(2'd0, 11'd2040, 10'd1020, 1'b1);
      frame_pulse();
      run_pixel(11'd0, 10'd1020, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL wrap_x got=%b exp=0", h5); end
      run_pixel(11'd2040, 10'd0, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL wrap_y got=%b exp=0", h5); end
      run_pixel(11'd2040, 10'd1020, a, h4, h5, i5);
      total++; if (h5 !== 1'b1 || a !== 12'd0) begin bad++; $display("FAIL edge_origin got=%b/%0d exp=1/0", h5, a); end
      run_pixel(11'd2047, 10'd1023, a, h4, h5, i5);
      total++; if (h5 !== 1'b1 || i5 !== 2'd0) begin bad++; $display("FAIL edge_hit got=%b/%0d exp=1/0", h5, i5); end
      total++; if (a !== 12'd103) begin bad++; $display("FAIL edge_addr got=%0d exp=103", a); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); hcount = 11'd2047; vcount = 10'd1023;
      repeat (6) @(negedge clk);
      total++; if (hit !== 1'b1) begin bad++; $display("FAIL pre_reset_hit got=%b exp=1", hit); end
      rst_n = 1'b0;
      #1;
      total++; if (hit !== 1'b0 || rom_addr !== 12'd0) begin bad++; $display("FAIL async_clear got=%b/%0d exp=0/0", hit, rom_addr); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL post_reset_hit got=%b exp=0", hit); end
      frame_pulse();
      run_pixel(11'd2047, 10'd1023, a, h4, h5, i5);
      total++; if (h5 !== 1'b0) begin bad++; $display("FAIL shadow_cleared got=%b exp=0", h5); end
      write_pos(2'd0, 11'd100, 10'd50, 1'b1);
      frame_pulse();
      run_pixel(11'd100, 10'd50, a, h4, h5, i5);
      total++; if (h5 !== 1'b1) begin bad++; $display("FAIL recover_hit got=%b exp=1", h5); end
   endtask

   initial begin
      hcount = IDLE_H; vcount = IDLE_V; fs = 1'b0; rst_n = 1'b0;
      pif.pos_valid_in = 1'b0; pif.pos_id_in = 2'd0;
      pif.pos_x_in = 11'd0; pif.pos_y_in = 10'd0; pif.pos_en_in = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_shadow_commit();
      test_back_to_back();
      test_edge();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
